// File: rtl/downmem_responder.sv
// Downstream memory responder: fixed-latency line read and write-accumulate backing store.
// Optional macro DOWNMEM_SATURATE_EN makes the write accumulate saturate instead of wrapping.
module downmem_responder #(
  parameter int DEPTH  = 122,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int LAT_RD = 5,
  parameter int LAT_WR = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_valid,
  input  logic              mem_req_rw,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [ADDR_W-1:0] mem_req_wraddr,
  input  logic [DATA_W-1:0] mem_req_data,
  output logic [DATA_W-1:0] mem_data_down_data,
  output logic              mem_data_down_ready,
  output logic              mem_err,
  output logic              busy
);

  // state   | meaning
  // IDLE    | waiting for mem_req_valid, request captured on accept
  // RD_WAIT | read latency countdown, line registered on terminal count
  // WR_WAIT | write latency countdown, line accumulated on terminal count
  // DONE    | ready pulse cycle, mem_err valid

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int LAT_MAX = (LAT_RD > LAT_WR) ? LAT_RD : LAT_WR;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx_q;
  logic              oor_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              ready_q;
  logic              err_q;
  logic              busy_q;

  // Memory powers up cleared; rst deliberately leaves contents alone.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_W-1:0] acc;
  logic              last_cnt;
  logic              commit;

`ifdef DOWNMEM_SATURATE_EN
  logic [DATA_W:0] sum;
  always_comb begin
    sum = {1'b0, mem[idx_q]} + {1'b0, data_q};
    acc = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
  end
`else
  always_comb begin
    acc = mem[idx_q] + data_q;
  end
`endif

  assign last_cnt = (cnt == CNT_W'(1));
  assign commit   = (state == WR_WAIT) && last_cnt && !oor_q && !rst;

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[idx_q] <= acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      oor_q     <= 1'b0;
      data_q    <= '0;
      rd_data_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req_valid) begin
            busy_q <= 1'b1;
            data_q <= mem_req_data;
            if (mem_req_rw) begin
              idx_q <= mem_req_wraddr[IDX_W-1:0];
              oor_q <= (mem_req_wraddr >= ADDR_W'(DEPTH));
              cnt   <= CNT_W'(LAT_WR - 1);
              state <= WR_WAIT;
            end else begin
              idx_q <= mem_req_addr[IDX_W-1:0];
              oor_q <= (mem_req_addr >= ADDR_W'(DEPTH));
              cnt   <= CNT_W'(LAT_RD - 1);
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (last_cnt) begin
            rd_data_q <= oor_q ? '0 : mem[idx_q];
            ready_q   <= 1'b1;
            err_q     <= oor_q;
            state     <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR_WAIT: begin
          // Read data register is left untouched by writes.
          if (last_cnt) begin
            ready_q <= 1'b1;
            err_q   <= oor_q;
            state   <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_data_down_data  = rd_data_q;
  assign mem_data_down_ready = ready_q;
  assign mem_err             = err_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_downmem_responder.sv
// Directed table-driven bench for downmem_responder: latency, busy window, accumulate, range and reset.
module tb_downmem_responder;

  localparam int LAT_RD = 5;
  localparam int LAT_WR = 7;
`ifdef DOWNMEM_SATURATE_EN
  localparam logic [127:0] OVF_EXP = {128{1'b1}};
`else
  localparam logic [127:0] OVF_EXP = 128'h1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic         rw = 1'b0;
  logic [31:0]  addr = '0;
  logic [31:0]  wraddr = '0;
  logic [127:0] wdata = '0;
  logic [127:0] dout;
  logic         ready;
  logic         err;
  logic         busy;

  downmem_responder dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_req_valid       (valid),
    .mem_req_rw          (rw),
    .mem_req_addr        (addr),
    .mem_req_wraddr      (wraddr),
    .mem_req_data        (wdata),
    .mem_data_down_data  (dout),
    .mem_data_down_ready (ready),
    .mem_err             (err),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rw;
    logic [31:0]  a;
    logic [127:0] d;
    logic [127:0] exp_data;
    logic         exp_err;
  } vec_t;

  vec_t vecs[12];

  // Called at a negedge in an IDLE cycle; returns at the negedge of the following IDLE cycle.
  task automatic run_req(input string tag, input logic r, input logic [31:0] a,
                         input logic [127:0] d, input bit change_mid,
                         output logic [127:0] rdata, output logic rerr);
    int lat;
    bit busy_ok;
    lat     = 0;
    rdata   = '0;
    rerr    = 1'b0;
    busy_ok = (busy === 1'b0);
    valid   = 1'b1;
    rw      = r;
    addr    = r ? 32'd5 : a;
    wraddr  = r ? a : 32'd5;
    wdata   = d;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (i == 2 && change_mid) begin
        addr   = 32'd7;
        wraddr = 32'd7;
        wdata  = 128'hffff;
      end
      if (ready === 1'b1) begin
        lat   = i;
        rdata = dout;
        rerr  = err;
        break;
      end
    end
    valid = 1'b0;
    chk({tag, " latency"}, 128'(lat), 128'(r ? LAT_WR : LAT_RD));
    chk({tag, " busy_window"}, 128'(busy_ok), 128'h1);
    @(negedge clk);
    chk({tag, " ready_single_pulse"}, 128'({ready, busy}), 128'h0);
  endtask

  initial begin
    logic [127:0] rd;
    logic         er;
    bit           saw_ready;

    vecs[0]  = '{1'b0, 32'd3,   128'h0,          128'h0,  1'b0};
    vecs[1]  = '{1'b1, 32'd7,   128'h10,         128'h0,  1'b0};
    vecs[2]  = '{1'b1, 32'd7,   128'h25,         128'h0,  1'b0};
    vecs[3]  = '{1'b0, 32'd7,   128'h0,          128'h35, 1'b0};
    vecs[4]  = '{1'b1, 32'd122, 128'h1,          128'h35, 1'b1};
    vecs[5]  = '{1'b0, 32'd122, 128'h0,          128'h0,  1'b1};
    vecs[6]  = '{1'b0, 32'd121, 128'h0,          128'h0,  1'b0};
    vecs[7]  = '{1'b0, 32'd0,   128'h0,          128'h0,  1'b0};
    vecs[8]  = '{1'b1, 32'd0,   {128{1'b1}},     128'h0,  1'b0};
    vecs[9]  = '{1'b1, 32'd0,   128'h2,          128'h0,  1'b0};
    vecs[10] = '{1'b0, 32'd0,   128'h0,          OVF_EXP, 1'b0};
    vecs[11] = '{1'b0, 32'd7,   128'h0,          128'h35, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_hold outputs", {dout[123:0], ready, err, busy, 1'b0}, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_release data", dout, 128'h0);
    chk("reset_release flags", 128'({ready, err, busy}), 128'h0);

    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_req(tag, vecs[i].rw, vecs[i].a, vecs[i].d, 1'b0, rd, er);
      chk({tag, " data"}, rd, vecs[i].exp_data);
      chk({tag, " err"}, 128'(er), 128'(vecs[i].exp_err));
    end

    // Reset during a write: the pending accumulate must be dropped.
    valid  = 1'b1;
    rw     = 1'b1;
    wraddr = 32'd9;
    addr   = 32'd5;
    wdata  = 128'h5;
    saw_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (ready === 1'b1) saw_ready = 1'b1;
    end
    rst   = 1'b1;
    valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ready === 1'b1) saw_ready = 1'b1;
      if (i == 2) rst = 1'b0;
    end
    chk("midreset no_ready", 128'(saw_ready), 128'h0);
    chk("midreset outputs", 128'({dout[124:0], err, busy}), 128'h0);
    run_req("midreset_read", 1'b0, 32'd9, 128'h0, 1'b0, rd, er);
    chk("midreset_read data", rd, 128'h0);

    // Input changes after accept must not affect the transaction.
    run_req("prep_w2", 1'b1, 32'd2, 128'hab, 1'b0, rd, er);
    chk("prep_w2 held_data", rd, 128'h0);
    run_req("chg_read", 1'b0, 32'd2, 128'h0, 1'b1, rd, er);
    chk("chg_read data", rd, 128'hab);
    run_req("chg_write", 1'b1, 32'd2, 128'h1, 1'b1, rd, er);
    chk("chg_write held_data", rd, 128'hab);
    run_req("chk_line2", 1'b0, 32'd2, 128'h0, 1'b0, rd, er);
    chk("chk_line2 data", rd, 128'hac);
    run_req("chk_line7", 1'b0, 32'd7, 128'h0, 1'b0, rd, er);
    chk("chk_line7 data", rd, 128'h35);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
